// File: rtl/ntt_poly_reduce.sv
// ntt_poly_reduce
//   In-place Barrett reduction of one 256-coefficient Kyber polynomial held in
//   the shared 256x16 NTT BRAM. One coefficient per cycle streams through a
//   4-stage arithmetic pipeline behind a synchronous (1-cycle) BRAM read.
//
//   Build option: POLY_REDUCE_CANONICAL_EN
//     defined     -> output in [0, 3328], zero-extended 12-bit value
//     not defined -> output in [-1664, 1664], sign-extended
//
// Ports
//   clk               rising-edge clock
//   reset_n           asynchronous active-low reset
//   enable            start pulse, sampled only in IDLE
//   Coef_RData        BRAM read data (valid one cycle after Coef_RAd)
//   Coef_RAd          BRAM read address
//   Coef_WEN          BRAM write enable
//   Coef_WAd          BRAM write address
//   Coef_WData        reduced coefficient
//   Poly_Reduce_done  one-cycle completion pulse
module ntt_poly_reduce (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [15:0] Coef_RData,
   output logic [7:0]  Coef_RAd,
   output logic        Coef_WEN,
   output logic [7:0]  Coef_WAd,
   output logic [15:0] Coef_WData,
   output logic        Poly_Reduce_done
);

   localparam int unsigned KYBER_N = 256;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned P_W     = 32;
   localparam int unsigned T_W     = 5;   // |t| <= 10 for any 16-bit input
   localparam int unsigned R_W     = 17;

   localparam logic signed [P_W-1:0]    BARRETT_V = 32'sd20159;
   localparam logic signed [P_W-1:0]    ROUND_C   = 32'sd33554432;  // 2^25
   localparam logic signed [R_W-1:0]    Q_R       = 17'sd3329;
   localparam logic signed [DATA_W-1:0] Q_D       = 16'sd3329;
   localparam logic [ADDR_W-1:0]        LAST_AD   = ADDR_W'(KYBER_N - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic [ADDR_W-1:0] w_rad_nxt;
   logic              w_issue;
   logic              w_done_nxt;

   // Pipeline: rd (address out) -> dat (BRAM data) -> S1 -> S2 -> S3 -> S4 (outputs)
   logic                     r_v_rd;
   logic                     r_v_dat;
   logic [ADDR_W-1:0]        r_ad_dat;
   logic                     r_v1, r_v2, r_v3;
   logic [ADDR_W-1:0]        r_ad1, r_ad2, r_ad3;
   logic signed [DATA_W-1:0] r_a1, r_a2;
   logic signed [P_W-1:0]    r_p1;
   logic signed [T_W-1:0]    r_t2;
   logic signed [DATA_W-1:0] r_r3;

   logic signed [DATA_W-1:0] w_a;
   logic signed [P_W-1:0]    w_p;
   logic signed [P_W-1:0]    w_sum;
   logic signed [R_W-1:0]    w_r;

   // Next-state and registered-output targets
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rad_nxt   = Coef_RAd;
      w_issue     = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_rad_nxt = '0;
            w_cnt_nxt = '0;
            if (enable) w_state_nxt = S_READ;
         end
         S_READ: begin
            w_rad_nxt = r_cnt;
            w_issue   = 1'b1;
            w_cnt_nxt = r_cnt + ADDR_W'(1);
            if (r_cnt == LAST_AD) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // Last write is on the bus this cycle; done follows next cycle
            if (Coef_WEN && (Coef_WAd == LAST_AD)) begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
            end
         end
         S_DONE: begin
            w_rad_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_rad_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM and address-side registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state          <= S_IDLE;
         r_cnt            <= '0;
         Coef_RAd         <= '0;
         r_v_rd           <= 1'b0;
         Poly_Reduce_done <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_cnt            <= w_cnt_nxt;
         Coef_RAd         <= w_rad_nxt;
         r_v_rd           <= w_issue;
         Poly_Reduce_done <= w_done_nxt;
      end
   end

   // Barrett arithmetic
   assign w_a   = Coef_RData;
   assign w_p   = P_W'(w_a) * BARRETT_V;
   assign w_sum = r_p1 + ROUND_C;
   assign w_r   = R_W'(r_a2) - (R_W'(r_t2) * Q_R);

   // Data pipeline with address/valid tags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_v_dat    <= 1'b0;
         r_ad_dat   <= '0;
         r_v1       <= 1'b0;
         r_ad1      <= '0;
         r_a1       <= '0;
         r_p1       <= '0;
         r_v2       <= 1'b0;
         r_ad2      <= '0;
         r_a2       <= '0;
         r_t2       <= '0;
         r_v3       <= 1'b0;
         r_ad3      <= '0;
         r_r3       <= '0;
         Coef_WEN   <= 1'b0;
         Coef_WAd   <= '0;
         Coef_WData <= '0;
      end else begin
         r_v_dat  <= r_v_rd;
         r_ad_dat <= Coef_RAd;
         // S1: product
         r_v1  <= r_v_dat;
         r_ad1 <= r_ad_dat;
         r_a1  <= w_a;
         r_p1  <= w_p;
         // S2: rounded quotient estimate
         r_v2  <= r_v1;
         r_ad2 <= r_ad1;
         r_a2  <= r_a1;
         r_t2  <= T_W'(w_sum >>> 26);
         // S3: remainder, always within +/-1664 so 16 bits suffice
         r_v3  <= r_v2;
         r_ad3 <= r_ad2;
         r_r3  <= DATA_W'(w_r);
         // S4: optional canonical correction
         Coef_WEN <= r_v3;
         Coef_WAd <= r_ad3;
`ifdef POLY_REDUCE_CANONICAL_EN
         Coef_WData <= {4'b0000, 12'(r_r3[DATA_W-1] ? (r_r3 + Q_D) : r_r3)};
`else
         Coef_WData <= r_r3;
`endif
      end
   end

endmodule

// File: tb/tb_ntt_poly_reduce.sv
// Scoreboard bench for ntt_poly_reduce: behavioural synchronous BRAM, expected
// writes/done cycles queued at start, monitor pops on every write/done.
module tb_ntt_poly_reduce;

   typedef struct {
      int          cyc;
      logic [7:0]  ad;
      logic [15:0] d;
   } wexp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [15:0] Coef_RData;
   logic [7:0]  Coef_RAd;
   logic        Coef_WEN;
   logic [7:0]  Coef_WAd;
   logic [15:0] Coef_WData;
   logic        Poly_Reduce_done;

   logic [15:0] mem  [256];
   logic [15:0] init [256];
   logic [15:0] expd [256];
   logic        do_load = 1'b0;

   wexp_t wq[$];
   int    dq[$];
   int    cyc    = 0;
   int    rad_c0 = -100000;
   int    total  = 0;
   int    bad    = 0;

   ntt_poly_reduce dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .enable           (enable),
      .Coef_RData       (Coef_RData),
      .Coef_RAd         (Coef_RAd),
      .Coef_WEN         (Coef_WEN),
      .Coef_WAd         (Coef_WAd),
      .Coef_WData       (Coef_WData),
      .Poly_Reduce_done (Poly_Reduce_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read BRAM model; bench loads go through the same process
   always @(posedge clk) begin
      Coef_RData <= mem[Coef_RAd];
      if (do_load) mem = init;
      else if (Coef_WEN) mem[Coef_WAd] = Coef_WData;
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (reset_n) begin
         if (Coef_WEN) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               wexp_t e;
               e = wq.pop_front();
               chk("wr_cycle", cyc, e.cyc);
               chk("wr_addr", int'(Coef_WAd), int'(e.ad));
               chk("wr_data", int'(Coef_WData), int'(e.d));
            end
         end
         if (Poly_Reduce_done) begin
            if (dq.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_cycle", cyc, dq.pop_front());
         end
         if (cyc >= rad_c0 + 1 && cyc <= rad_c0 + 256)
            chk("rd_addr", int'(Coef_RAd), (cyc - rad_c0 - 1) & 255);
      end
   end

   task automatic push_run(input int c0);
      for (int i = 0; i < 256; i++) wq.push_back('{c0 + 6 + i, 8'(i), expd[i]});
      dq.push_back(c0 + 262);
   endtask

   task automatic load_mem();
      @(negedge clk);
      do_load = 1'b1;
      @(negedge clk);
      do_load = 1'b0;
   endtask

   task automatic start_run(output int c0);
      @(negedge clk);
      enable = 1'b1;
      c0     = cyc + 1;
      rad_c0 = c0;
      push_run(c0);
      @(negedge clk);
      enable = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((wq.size() != 0 || dq.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", wq.size() + dq.size(), 0);
   endtask

   task automatic check_outs_zero(input string tag);
      chk({tag, "_rad"},  int'(Coef_RAd), 0);
      chk({tag, "_wen"},  int'(Coef_WEN), 0);
      chk({tag, "_wad"},  int'(Coef_WAd), 0);
      chk({tag, "_wdat"}, int'(Coef_WData), 0);
      chk({tag, "_done"}, int'(Poly_Reduce_done), 0);
   endtask

   task automatic set_vectors();
      logic [15:0] vin [6];
      logic [15:0] vex [6];
      vin = '{16'd3329, 16'd3328, 16'd6658, 16'hFFFF, 16'd32767, 16'h8000};
`ifdef POLY_REDUCE_CANONICAL_EN
      vex = '{16'd0, 16'd3328, 16'd0, 16'd3328, 16'd2806, 16'd522};
`else
      vex = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFDF5, 16'd522};
`endif
      for (int i = 0; i < 256; i++) begin
         init[i] = 16'd0;
         expd[i] = 16'd0;
      end
      for (int i = 0; i < 6; i++) begin
         init[i] = vin[i];
         expd[i] = vex[i];
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      reset_n = 1'b0;
      enable  = 1'b0;
      for (int i = 0; i < 256; i++) init[i] = 16'd0;
      repeat (3) @(negedge clk);
      check_outs_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // All-zero polynomial
      for (int i = 0; i < 256; i++) expd[i] = 16'd0;
      load_mem();
      start_run(c0);
      drain(400);
      repeat (20) @(negedge clk);

      // Edge-value vectors
      set_vectors();
      load_mem();
      start_run(c0);
      drain(400);
      for (int i = 0; i < 6; i++) chk("mem_after_vec", int'(mem[i]), int'(expd[i]));

      // Identity polynomial
      for (int i = 0; i < 256; i++) begin
         init[i] = 16'(i);
         expd[i] = 16'(i);
      end
      load_mem();
      start_run(c0);
      drain(400);
      chk("mem_identity_last", int'(mem[255]), 255);

      // enable held high: exactly one pass, the next only after IDLE
      @(negedge clk);
      enable = 1'b1;
      c0     = cyc + 1;
      rad_c0 = c0;
      push_run(c0);
      push_run(c0 + 264);
      while (cyc < c0 + 274) @(negedge clk);
      enable = 1'b0;
      drain(700);
      repeat (300) @(negedge clk);

      // Reset mid-run
      set_vectors();
      load_mem();
      start_run(c0);
      while (cyc < c0 + 100) @(negedge clk);
      reset_n = 1'b0;
      wq.delete();
      dq.delete();
      rad_c0 = -100000;
      #1;
      check_outs_zero("midreset");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      load_mem();
      start_run(c0);
      drain(400);
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
